// File: rtl/centroid_pkg.sv
// centroid_pkg: shared widths and control-state encoding for the centroid calculator
package centroid_pkg;
    localparam int X_W = 11;
    localparam int Y_W = 11;
    localparam int M00_W = 20;
    localparam int M_W = 32;
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle, DW cycles per divide
module seq_divider #(
    parameter int DW = 32,
    parameter int VW = 20,
    parameter int QW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam int CW = $clog2(DW);
    logic [DW-1:0] q, q_src, q_next;
    logic [VW-1:0] rem, rem_src, rem_next;
    logic [VW:0] sh, diff;
    logic [CW-1:0] cnt;
    logic ge;
    // operands are read straight from the ports on the first iteration, so they must hold while busy
    always_comb begin
        q_src = (cnt == '0) ? dividend : q;
        rem_src = (cnt == '0) ? '0 : rem;
        sh = {rem_src, q_src[DW-1]};
        diff = sh - {1'b0, divisor};
        ge = !diff[VW];
        rem_next = ge ? diff[VW-1:0] : sh[VW-1:0];
        q_next = {q_src[DW-2:0], ge};
    end
    assign quotient = q[QW-1:0];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt <= '0;
            q <= '0;
            rem <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                q <= q_next;
                rem <= rem_next;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(DW - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                busy <= 1'b1;
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/centroid_calc.sv
// centroid_calc: per-frame mask moments divided into a centroid, with 1-cycle video passthrough
module centroid_calc
    import centroid_pkg::*;
#(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 720
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           de,
    input  logic           hsync,
    input  logic           vsync,
    input  logic [23:0]    pixel_in,
    output logic           de_out,
    output logic           hsync_out,
    output logic           vsync_out,
    output logic [23:0]    pixel_out,
    output logic [X_W-1:0] x_center,
    output logic [Y_W-1:0] y_center,
    output logic           centroid_valid
);
    if (IMG_W > (1 << X_W) || IMG_H > (1 << Y_W)) begin : g_size_check
        $error("image size exceeds position counter width");
    end
    logic [X_W-1:0] x_cnt, x_q;
    logic [Y_W-1:0] y_cnt, y_q;
    logic [M00_W-1:0] m00, s00;
    logic [M_W-1:0] m10, m01, s10, s01;
    state_t state;
    logic frame_end, line_end, obj, idle, start, fin;
    logic x_busy, y_busy, x_done, y_done;
    assign frame_end = vsync && !vsync_out;
    assign line_end = !de && de_out;
    assign obj = de && pixel_in != '0;
    assign idle = state == IDLE && !x_busy && !y_busy;
    assign start = frame_end && idle && m00 != '0;
    assign fin = state == DIV && x_done && y_done;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_out <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            pixel_out <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
            m00 <= '0;
            m10 <= '0;
            m01 <= '0;
            s00 <= '0;
            s10 <= '0;
            s01 <= '0;
            state <= IDLE;
            x_center <= '0;
            y_center <= '0;
            centroid_valid <= 1'b0;
        end else begin
            de_out <= de;
            hsync_out <= hsync;
            vsync_out <= vsync;
            pixel_out <= pixel_in;
            x_cnt <= (frame_end || line_end) ? '0 : de ? x_cnt + X_W'(1) : x_cnt;
            y_cnt <= frame_end ? '0 : line_end ? y_cnt + Y_W'(1) : y_cnt;
            if (frame_end) begin
                m00 <= '0;
                m10 <= '0;
                m01 <= '0;
            end else if (obj) begin
                m00 <= m00 + M00_W'(1);
                m10 <= m10 + M_W'(x_cnt);
                m01 <= m01 + M_W'(y_cnt);
            end
            // snapshots feed the running dividers, so a frame end during a divide must not disturb them
            if (frame_end && idle) begin
                s00 <= m00;
                s10 <= m10;
                s01 <= m01;
            end
            state <= state == IDLE ? (start ? DIV : IDLE) : state == DIV ? (fin ? DONE : DIV) : IDLE;
            centroid_valid <= fin;
            if (fin) begin
                x_center <= x_q;
                y_center <= y_q;
            end
        end
    end
    seq_divider #(.DW(M_W), .VW(M00_W), .QW(X_W)) u_div_x (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(s10), .divisor(s00),
        .busy(x_busy), .done(x_done), .quotient(x_q)
    );
    seq_divider #(.DW(M_W), .VW(M00_W), .QW(Y_W)) u_div_y (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(s01), .divisor(s00),
        .busy(y_busy), .done(y_done), .quotient(y_q)
    );
endmodule
